mem_port_arbiter: RTL and testbench

- Shares the single-port unified instruction/data memory between two requesters: the multicycle CPU control path (fetch, load, store) and the program loader/debug port.
- Sits between both requesters and the memory macro. It arbitrates, latches the request, holds the memory interface for a fixed access latency, then returns a one-cycle acknowledge with read data.
- The CPU FSM stalls on its memory states until cpu_ack.

---
 rtl/mem_port_arbiter_pkg.sv | 27 ++
 rtl/arb_latency_counter.sv | 28 ++
 rtl/mem_port_arbiter.sv | 126 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and limits for the unified-memory port arbiter.
// Holds the FSM state encoding, the owner encoding and the latency counter sizing.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_ACCESS = 2'd1,
    ARB_RESP   = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_LD  = 1'b1
  } owner_t;

  localparam int CNT_W       = 4;
  localparam int MEM_LAT_MIN = 1;
  localparam int MEM_LAT_MAX = 15;

  // Out-of-range latencies are pulled back into the range the counter can hold.
  function automatic int clamp_latency(input int lat);
    if (lat < MEM_LAT_MIN) return MEM_LAT_MIN;
    if (lat > MEM_LAT_MAX) return MEM_LAT_MAX;
    return lat;
  endfunction

endpackage

// File: rtl/arb_latency_counter.sv
// Down-counter that times the memory access phase of one transaction.
// Ports: clk, reset (sync, active-high), load/load_val, dec, zero flag.
module arb_latency_counter
  import mem_port_arbiter_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-port unified memory between the CPU and the loader.
// Ports: cpu_* and ld_* requester sets, mem_* macro interface, busy, owner.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MEM_LATENCY = 2,
  parameter int LD_PRIORITY = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              ld_req,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  output logic              ld_ack,
  output logic [DATA_W-1:0] ld_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              owner
);

  localparam int LAT = clamp_latency(MEM_LATENCY);
  localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(LAT - 1);

  arb_state_t state;
  owner_t     own;
  owner_t     last_grant;
  owner_t     pick;
  logic       any_req;
  logic       cnt_zero;

  assign any_req = cpu_req | ld_req;
  assign busy    = (state != ARB_IDLE);
  assign owner   = own;

  // Ties go to the loader when it has priority, else to whoever
  // was not served last.
  always_comb begin
    pick = OWN_CPU;
    unique case (1'b1)
      cpu_req && ld_req: begin
        if (LD_PRIORITY != 0) pick = OWN_LD;
        else if (last_grant == OWN_LD) pick = OWN_CPU;
        else pick = OWN_LD;
      end
      ld_req && !cpu_req: pick = OWN_LD;
      default: pick = OWN_CPU;
    endcase
  end

  arb_latency_counter u_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     ((state == ARB_IDLE) && any_req),
    .load_val (LAT_M1),
    .dec      (state == ARB_ACCESS),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ARB_IDLE;
      own        <= OWN_CPU;
      last_grant <= OWN_LD;
      cpu_ack    <= 1'b0;
      ld_ack     <= 1'b0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      cpu_rdata  <= '0;
      ld_rdata   <= '0;
    end else begin
      cpu_ack <= 1'b0;
      ld_ack  <= 1'b0;
      unique case (state)
        ARB_IDLE: begin
          if (any_req) begin
            own    <= pick;
            mem_en <= 1'b1;
            if (pick == OWN_LD) begin
              mem_we    <= ld_we;
              mem_addr  <= ld_addr;
              mem_wdata <= ld_wdata;
            end else begin
              mem_we    <= cpu_we;
              mem_addr  <= cpu_addr;
              mem_wdata <= cpu_wdata;
            end
            state <= ARB_ACCESS;
          end
        end
        ARB_ACCESS: begin
          if (cnt_zero) begin
            mem_en <= 1'b0;
            mem_we <= 1'b0;
            if (own == OWN_LD) begin
              ld_ack <= 1'b1;
              if (!mem_we) ld_rdata <= mem_rdata;
            end else begin
              cpu_ack <= 1'b1;
              if (!mem_we) cpu_rdata <= mem_rdata;
            end
            last_grant <= own;
            state      <= ARB_RESP;
          end
        end
        ARB_RESP: state <= ARB_IDLE;
        default:  state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: reset, tie alternation, table of
// single-port transactions, loader priority and reset during an access.
module tb_mem_port_arbiter;

  localparam int LAT = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        cpu_req, cpu_we, cpu_ack;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        ld_req, ld_we, ld_ack;
  logic [31:0] ld_addr, ld_wdata, ld_rdata;
  logic        mem_en, mem_we, busy, owner;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  logic        p_cpu_req, p_cpu_ack, p_ld_req, p_ld_ack;
  logic [31:0] p_cpu_addr, p_cpu_rdata, p_ld_addr, p_ld_rdata;
  logic        p_mem_en, p_mem_we, p_busy, p_owner;
  logic [31:0] p_mem_addr, p_mem_wdata, p_mem_rdata;

  logic [31:0] mem [256] = '{16: 32'hDEADBEEF, default: 32'h0};

  assign mem_rdata = mem[mem_addr[9:2]];
  always @(posedge clk) begin
    if (mem_en && mem_we) mem[mem_addr[9:2]] <= mem_wdata;
  end

  assign p_mem_rdata = {16'hCAFE, p_mem_addr[15:0]};

  mem_port_arbiter #(.MEM_LATENCY(LAT), .LD_PRIORITY(0)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr),
    .ld_wdata(ld_wdata), .ld_ack(ld_ack), .ld_rdata(ld_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy), .owner(owner)
  );

  mem_port_arbiter #(.MEM_LATENCY(LAT), .LD_PRIORITY(1)) dut_p (
    .clk(clk), .reset(reset),
    .cpu_req(p_cpu_req), .cpu_we(1'b0), .cpu_addr(p_cpu_addr),
    .cpu_wdata(32'h0), .cpu_ack(p_cpu_ack), .cpu_rdata(p_cpu_rdata),
    .ld_req(p_ld_req), .ld_we(1'b0), .ld_addr(p_ld_addr),
    .ld_wdata(32'h0), .ld_ack(p_ld_ack), .ld_rdata(p_ld_rdata),
    .mem_en(p_mem_en), .mem_we(p_mem_we), .mem_addr(p_mem_addr),
    .mem_wdata(p_mem_wdata), .mem_rdata(p_mem_rdata),
    .busy(p_busy), .owner(p_owner)
  );

  typedef struct {
    logic        ld;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } vec_t;

  int total = 0;
  int bad = 0;
  logic [31:0] exp_cpu = 32'h0;
  logic [31:0] exp_ld = 32'h0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic run_txn(input vec_t v);
    cpu_req = !v.ld; ld_req = v.ld;
    if (v.ld) begin
      ld_we = v.we; ld_addr = v.addr; ld_wdata = v.wdata;
    end else begin
      cpu_we = v.we; cpu_addr = v.addr; cpu_wdata = v.wdata;
    end
    @(posedge clk);
    for (int i = 0; i < LAT; i++) begin
      @(negedge clk);
      chk("acc_en", 32'(mem_en), 32'd1);
      chk("acc_addr", mem_addr, v.addr);
      chk("acc_we", 32'(mem_we), 32'(v.we));
      if (v.we) chk("acc_wdata", mem_wdata, v.wdata);
      chk("acc_acks", 32'({cpu_ack, ld_ack}), 32'd0);
    end
    @(negedge clk);
    if (!v.we) begin
      if (v.ld) exp_ld = v.rdata;
      else exp_cpu = v.rdata;
    end
    chk("resp_cpu_ack", 32'(cpu_ack), 32'(!v.ld));
    chk("resp_ld_ack", 32'(ld_ack), 32'(v.ld));
    chk("resp_en", 32'(mem_en), 32'd0);
    chk("resp_owner", 32'(owner), 32'(v.ld));
    chk("resp_cpu_rdata", cpu_rdata, exp_cpu);
    chk("resp_ld_rdata", ld_rdata, exp_ld);
    cpu_req = 1'b0; ld_req = 1'b0;
    @(negedge clk);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_acks", 32'({cpu_ack, ld_ack}), 32'd0);
  endtask

  vec_t vecs [5];

  initial begin
    vecs[0] = '{1'b0, 1'b0, 32'h40, 32'h0, 32'hDEADBEEF};
    vecs[1] = '{1'b1, 1'b1, 32'h10, 32'h12345678, 32'h0};
    vecs[2] = '{1'b1, 1'b0, 32'h10, 32'h0, 32'h12345678};
    vecs[3] = '{1'b0, 1'b1, 32'h44, 32'hAABBCCDD, 32'h0};
    vecs[4] = '{1'b0, 1'b0, 32'h44, 32'h0, 32'hAABBCCDD};

    reset = 1'b1;
    cpu_we = 1'b0; cpu_addr = 32'h40; cpu_wdata = 32'h0;
    ld_we = 1'b0; ld_addr = 32'h0; ld_wdata = 32'h0;
    cpu_req = 1'b1; ld_req = 1'b1;
    p_cpu_req = 1'b0; p_ld_req = 1'b0;
    p_cpu_addr = 32'h8; p_ld_addr = 32'hC;

    // Reset with both requests pending, then alternating ties.
    repeat (2) begin
      @(negedge clk);
      chk("rst_en", 32'(mem_en), 32'd0);
      chk("rst_acks", 32'({cpu_ack, ld_ack}), 32'd0);
      chk("rst_owner", 32'(owner), 32'd0);
    end
    reset = 1'b0;
    @(posedge clk);
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      chk("rr_cpu_ack", 32'(cpu_ack), 32'((c == 2) || (c == 10)));
      chk("rr_ld_ack", 32'(ld_ack), 32'((c == 6) || (c == 14)));
      chk("rr_owner", 32'(owner), 32'((c / 4) % 2));
      chk("rr_en", 32'(mem_en), 32'((c % 4) < 2));
      if (c == 2) chk("rr_cpu_rdata", cpu_rdata, 32'hDEADBEEF);
      if (c == 14) begin
        cpu_req = 1'b0; ld_req = 1'b0;
      end
    end
    exp_cpu = 32'hDEADBEEF;
    exp_ld = 32'h0;

    foreach (vecs[i]) run_txn(vecs[i]);

    // Loader priority: loader first, CPU queued behind it.
    p_cpu_req = 1'b1; p_ld_req = 1'b1;
    @(posedge clk);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      chk("pri_ld_ack", 32'(p_ld_ack), 32'(c == 2));
      chk("pri_cpu_ack", 32'(p_cpu_ack), 32'(c == 6));
      chk("pri_owner", 32'(p_owner), 32'(c < 4));
      if (c == 2) begin
        chk("pri_ld_rdata", p_ld_rdata, 32'hCAFE000C);
        p_ld_req = 1'b0;
      end
      if (c == 6) begin
        chk("pri_cpu_rdata", p_cpu_rdata, 32'hCAFE0008);
        p_cpu_req = 1'b0;
      end
    end

    // Reset lands one edge into a CPU read.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h40;
    @(posedge clk);
    @(negedge clk);
    chk("abort_en_k", 32'(mem_en), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_en", 32'(mem_en), 32'd0);
    chk("abort_acks", 32'({cpu_ack, ld_ack}), 32'd0);
    reset = 1'b0; cpu_req = 1'b0;
    exp_cpu = 32'h0; exp_ld = 32'h0;
    repeat (3) begin
      @(negedge clk);
      chk("abort_no_ack", 32'(cpu_ack), 32'd0);
      chk("abort_rdata", cpu_rdata, 32'h0);
    end
    run_txn(vecs[4]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
